// File: rtl/input_conditioner_pkg.sv
// Shared clock-rate constants for the front-end input logic.
// Debounce defaults are derived from the board clock, never hard-coded in modules.
package input_conditioner_pkg;

   localparam int unsigned CLK_HZ           = 125_000_000;
   localparam int unsigned SAMPLE_PERIOD_US = 500;

   // 0.5 ms sample tick at 125 MHz -> 62500 cycles
   localparam int unsigned DEFAULT_SAMPLE_CNT_MAX = (CLK_HZ / 1_000_000) * SAMPLE_PERIOD_US;
   localparam int unsigned DEFAULT_PULSE_CNT_MAX  = 200;

endpackage

// File: rtl/input_conditioner_if.sv
// Raw input / conditioned output bundle for the input conditioner.
// The slave side is the conditioner; the master side drives the raw inputs.
interface input_conditioner_if #(
   parameter int WIDTH = 1
) ();

   logic [WIDTH-1:0] in_async;
   logic [WIDTH-1:0] out_level;
   logic [WIDTH-1:0] out_rise;

   modport master (
      output in_async,
      input  out_level,
      input  out_rise
   );

   modport slave (
      input  in_async,
      output out_level,
      output out_rise
   );

endinterface

// File: rtl/edge_detector.sv
// Registered rising-edge detector: one-cycle pulse on each 0->1 of level.
// The pulse is decoded from level and prev_q, both expected to be registers.
module edge_detector #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] level,
   output logic [WIDTH-1:0] rise
);

   logic [WIDTH-1:0] prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q <= '0;
      end else begin
         prev_q <= level;
      end
   end

   assign rise = level & ~prev_q;

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous inputs; output lags input by 2 cycles.
// Deliberately unreset so the chain keeps tracking the pin through reset.
module synchronizer #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk) begin
      meta_reg <= d;
      sync_reg <= meta_reg;
   end

   assign q = sync_reg;

endmodule

// File: rtl/input_conditioner.sv
// Per-channel sync, sampled debounce with saturating stability counter, and
// rising-edge pulse. One sample-tick counter is shared by all channels.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int WIDTH          = 1,
   parameter int SAMPLE_CNT_MAX = int'(DEFAULT_SAMPLE_CNT_MAX),
   parameter int PULSE_CNT_MAX  = int'(DEFAULT_PULSE_CNT_MAX)
) (
   input  logic                clk,
   input  logic                rst,
   input_conditioner_if.slave  bus
);

   localparam int SW = $clog2(SAMPLE_CNT_MAX);
   localparam int CW = $clog2(PULSE_CNT_MAX + 1);
   localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
   localparam logic [CW-1:0] CNT_FULL    = CW'(PULSE_CNT_MAX);

   logic [WIDTH-1:0] sync;
   logic [SW-1:0]    sample_cnt_reg;
   logic             tick;
   logic [CW-1:0]    cnt_reg  [WIDTH];
   logic [CW-1:0]    cnt_next [WIDTH];
   logic [WIDTH-1:0] level_q;

   synchronizer #(
      .WIDTH (WIDTH)
   ) u_sync (
      .clk (clk),
      .d   (bus.in_async),
      .q   (sync)
   );

   assign tick = (sample_cnt_reg == SAMPLE_LAST);

   // A low sync clears progress on any cycle; counting only advances on ticks.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
         assign cnt_next[gi] = !sync[gi]                          ? '0 :
                               (tick && cnt_reg[gi] < CNT_FULL)   ? cnt_reg[gi] + CW'(1) :
                                                                    cnt_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sample_cnt_reg <= '0;
         level_q        <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_reg[i] <= '0;
         end
      end else begin
         sample_cnt_reg <= tick ? '0 : sample_cnt_reg + SW'(1);
         for (int i = 0; i < WIDTH; i++) begin
            cnt_reg[i] <= cnt_next[i];
            level_q[i] <= (cnt_reg[i] == CNT_FULL);
         end
      end
   end

   edge_detector #(
      .WIDTH (WIDTH)
   ) u_edge (
      .clk   (clk),
      .rst   (rst),
      .level (level_q),
      .rise  (bus.out_rise)
   );

   assign bus.out_level = level_q;

endmodule
